pio_pulse_stretcher: RTL and testbench

Downstream consumer of the 8-bit Avalon output PIO in the NIOS DUT subsystem. It turns each PIO bit into either a level passthrough or a timed, retriggerable pulse. This lets firmware fire fixed-width strobes (DUT reset, IEC/cartridge test stimulus) with one set-register write instead of software timing loops. The busy vector is intended to feed an input PIO for firmware polling.

---
 rtl/pio_pulse_pkg.sv | 14 +
 rtl/pio_pulse_channel.sv | 83 ++++++++
 rtl/pio_pulse_stretcher.sv | 70 +++++++
 tb/tb_pio_pulse_stretcher.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/pio_pulse_pkg.sv
// Shared types and default constants for the PIO pulse stretcher.
// Channel state is a two-state enum so it can be probed directly.
package pio_pulse_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } chan_state_e;

    localparam int DEF_PRESCALE    = 50;
    localparam int DEF_PULSE_TICKS = 100;
    localparam int DEF_CNT_W       = 16;

endpackage

// File: rtl/pio_pulse_channel.sv
// One output channel: rise detect, retriggerable tick counter and registered output.
// Handshake-free: ctrl_i is sampled every clk; tick_i is a one-cycle strobe.
module pio_pulse_channel
    import pio_pulse_pkg::*;
#(
    parameter int PULSE_TICKS = DEF_PULSE_TICKS,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ctrl_i,
    input  logic        ctrl_prev_i,
    input  logic        mode_i,
    input  logic        tick_i,
    output logic        pulse_o,
    output chan_state_e state_o
);

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(PULSE_TICKS);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    chan_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;
    logic             rise;

    assign rise = ctrl_i & ~ctrl_prev_i;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    // A rise always wins over the terminating tick, so retrigger never glitches low.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!mode_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rise) begin
                        state_d = ST_ACTIVE;
                        cnt_d   = RELOAD;
                    end
                end
                ST_ACTIVE: begin
                    if (rise) begin
                        cnt_d = RELOAD;
                    end else if (tick_i) begin
                        if (cnt_q == ONE) begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q - ONE;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        pulse_d = mode_i ? (state_d == ST_ACTIVE) : ctrl_i;
    end

    assign pulse_o = pulse_q;
    assign state_o = state_q;

endmodule

// File: rtl/pio_pulse_stretcher.sv
// Per-bit level passthrough or timed retriggerable pulse for the output PIO.
// Holds the shared prescaler and the ctrl_in history register.
module pio_pulse_stretcher
    import pio_pulse_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int PRESCALE    = DEF_PRESCALE,
    parameter int PULSE_TICKS = DEF_PULSE_TICKS,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] ctrl_in,
    input  logic [WIDTH-1:0] mode_in,
    output logic [WIDTH-1:0] pulse_out,
    output logic [WIDTH-1:0] busy,
    output logic             tick
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    if (PULSE_TICKS < 1 || PRESCALE < 1 || ((64'(PULSE_TICKS) >> CNT_W) != 64'd0))
    begin : g_param_check
        $error("pio_pulse_stretcher: bad PRESCALE/PULSE_TICKS/CNT_W");
    end

    logic [WIDTH-1:0] ctrl_q;
    logic [PW-1:0]    presc_q, presc_d;
    logic             tick_q, tick_d;
    chan_state_e      ch_state [WIDTH];

    // tick is registered so it is low in reset even when PRESCALE is 1.
    always_comb begin
        presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
        tick_d  = (presc_d == PRESC_LAST);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q  <= '0;
            presc_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            ctrl_q  <= ctrl_in;
            presc_q <= presc_d;
            tick_q  <= tick_d;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        pio_pulse_channel #(
            .PULSE_TICKS(PULSE_TICKS),
            .CNT_W      (CNT_W)
        ) u_ch (
            .clk        (clk),
            .reset_n    (reset_n),
            .ctrl_i     (ctrl_in[i]),
            .ctrl_prev_i(ctrl_q[i]),
            .mode_i     (mode_in[i]),
            .tick_i     (tick_q),
            .pulse_o    (pulse_out[i]),
            .state_o    (ch_state[i])
        );
        assign busy[i] = (ch_state[i] == ST_ACTIVE);
    end

    assign tick = tick_q;

endmodule

// File: tb/tb_pio_pulse_stretcher.sv
// Self-checking bench for pio_pulse_stretcher with PRESCALE=4, PULSE_TICKS=3, WIDTH=8.
module tb_pio_pulse_stretcher;

  localparam int WIDTH       = 8;
  localparam int PRESCALE    = 4;
  localparam int PULSE_TICKS = 3;
  localparam int CNT_W       = 16;
  localparam int EW          = 2 * WIDTH + 1;

  logic             clk;
  logic             reset_n;
  logic [WIDTH-1:0] ctrl_in;
  logic [WIDTH-1:0] mode_in;
  logic [WIDTH-1:0] pulse_out;
  logic [WIDTH-1:0] busy;
  logic             tick;

  int checks;
  int failures;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  pio_pulse_stretcher #(
    .WIDTH      (WIDTH),
    .PRESCALE   (PRESCALE),
    .PULSE_TICKS(PULSE_TICKS),
    .CNT_W      (CNT_W)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .ctrl_in  (ctrl_in),
    .mode_in  (mode_in),
    .pulse_out(pulse_out),
    .busy     (busy),
    .tick     (tick)
  );

  // ---------------- reference model ----------------
  // Each channel is "remaining ticks"; tick falls on every PRESCALE-th cycle since release.
  logic [EW-1:0]    exp_q[$];
  int               m_k;
  logic [WIDTH-1:0] m_prev;
  int               m_left [WIDTH];

  task automatic model_reset();
    m_k    = 0;
    m_prev = '0;
    for (int i = 0; i < WIDTH; i++) m_left[i] = 0;
    exp_q.delete();
  endtask

  task automatic model_edge(input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] m);
    logic [WIDTH-1:0] rise, p, b;
    logic             tick_now;
    tick_now = (m_k >= 1) && (m_k % PRESCALE == PRESCALE - 1);
    rise = c & ~m_prev;
    for (int i = 0; i < WIDTH; i++) begin
      if (!m[i]) begin
        m_left[i] = 0;
        p[i] = c[i];
      end else begin
        if (rise[i]) m_left[i] = PULSE_TICKS;
        else if (m_left[i] > 0 && tick_now) m_left[i] = m_left[i] - 1;
        p[i] = (m_left[i] > 0);
      end
      b[i] = m[i] && (m_left[i] > 0);
    end
    m_prev = c;
    m_k++;
    exp_q.push_back({(m_k % PRESCALE == PRESCALE - 1), b, p});
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string name);
    logic [EW-1:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s: scoreboard empty at %0t", name, $time);
    end else begin
      e = exp_q.pop_front();
      if ({tick, busy, pulse_out} !== e) begin
        failures++;
        $display("FAIL %s: got tick=%b busy=%h pulse=%h expected tick=%b busy=%h pulse=%h at %0t",
                 name, tick, busy, pulse_out, e[EW-1], e[2*WIDTH-1:WIDTH], e[WIDTH-1:0], $time);
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] m, input string name);
    ctrl_in = c;
    mode_in = m;
    model_edge(c, m);
    @(posedge clk);
    #1;
    check_model(name);
  endtask

  // Counts high cycles of pulse_out[0] starting from a cycle already known high.
  task automatic measure_ch0(input string name);
    int w;
    w = 1;
    for (int n = 0; n < 40 && pulse_out[0]; n++) begin
      step(8'h00, 8'h01, name);
      if (pulse_out[0]) w++;
    end
    checks++;
    if (w < 9 || w > 12 || pulse_out[0] !== 1'b0) begin
      failures++;
      $display("FAIL %s_width: got %0d cycles expected 9..12", name, w);
    end
  endtask

  typedef struct {
    logic [WIDTH-1:0] ctrl;
    logic [WIDTH-1:0] mode;
    logic [WIDTH-1:0] exp_pulse;
    logic [WIDTH-1:0] exp_busy;
  } vec_t;

  vec_t tbl [9];

  initial begin
    logic [WIDTH-1:0] rc, rm;
    checks   = 0;
    failures = 0;

    tbl[0] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    tbl[1] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    tbl[2] = '{8'h00, 8'h00, 8'h00, 8'h00};
    tbl[3] = '{8'hA5, 8'h00, 8'hA5, 8'h00};
    tbl[4] = '{8'h5A, 8'h00, 8'h5A, 8'h00};
    tbl[5] = '{8'h00, 8'h00, 8'h00, 8'h00};
    tbl[6] = '{8'h00, 8'hFF, 8'h00, 8'h00};
    tbl[7] = '{8'h0F, 8'hF0, 8'h0F, 8'h00};
    tbl[8] = '{8'hF0, 8'hF0, 8'hF0, 8'hF0};

    // Reset with all inputs high.
    reset_n = 1'b0;
    ctrl_in = 8'hFF;
    mode_in = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_pulse", 32'(pulse_out), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_tick", 32'(tick), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();

    // Table vectors: first-edge fire, level mode, mode switches.
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].ctrl, tbl[i].mode, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d_pulse", i), 32'(pulse_out), 32'(tbl[i].exp_pulse));
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].exp_busy));
    end

    // Single pulse on ch0; others aborted to idle first.
    step(8'h00, 8'h01, "single_pre");
    step(8'h00, 8'h01, "single_pre");
    step(8'h01, 8'h01, "single_rise");
    chk("single_hi", 32'({busy, pulse_out}), 32'h0101);
    measure_ch0("single");

    // Retrigger after d cycles; sweeping d lands one rise on the terminating tick.
    for (int d = 2; d <= 13; d++) begin
      step(8'h00, 8'h01, "retrig_idle");
      step(8'h01, 8'h01, "retrig_rise1");
      for (int n = 0; n < d - 1; n++) step(8'h00, 8'h01, "retrig_gap");
      step(8'h01, 8'h01, "retrig_rise2");
      chk($sformatf("retrig_hi_d%0d", d), 32'(pulse_out[0]), 32'h1);
      measure_ch0($sformatf("retrig_d%0d", d));
    end

    // Abort ch3 mid-pulse by switching it to level with ctrl low.
    step(8'h00, 8'h08, "abort_pre");
    step(8'h08, 8'h08, "abort_rise");
    step(8'h00, 8'h08, "abort_run");
    step(8'h00, 8'h08, "abort_run");
    step(8'h00, 8'h00, "abort");
    chk("abort_pulse3", 32'(pulse_out[3]), 32'h0);
    chk("abort_busy3", 32'(busy[3]), 32'h0);

    // Randomised traffic against the model.
    rc = '0;
    rm = 8'($urandom_range(0, 255));
    for (int n = 0; n < 400; n++) begin
      if (n % 37 == 0) rm = 8'($urandom_range(0, 255));
      rc = rc ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      step(rc, rm, "random");
    end

    // Async reset while ch0 is active.
    step(8'h00, 8'h01, "areset_pre");
    step(8'h01, 8'h01, "areset_rise");
    step(8'h01, 8'h01, "areset_run");
    #2;
    reset_n = 1'b0;
    ctrl_in = 8'h00;
    #1;
    chk("areset_pulse", 32'(pulse_out), 32'h0);
    chk("areset_busy", 32'(busy), 32'h0);
    chk("areset_tick", 32'(tick), 32'h0);
    @(posedge clk);
    #2;
    chk("areset_hold", 32'({tick, busy, pulse_out}), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    for (int n = 0; n < 6; n++) begin
      step(8'h00, 8'h01, "areset_after");
      chk("areset_quiet", 32'(pulse_out[0]), 32'h0);
    end
    step(8'h01, 8'h01, "areset_newrise");
    chk("areset_newrise_hi", 32'(pulse_out[0]), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
